// File: rtl/gpio_controller.sv
// Memory-mapped GPIO block with a two-flop input synchroniser and per-pin debounce.
// Debounced edges set sticky write-1-to-clear interrupt status bits.
module gpio_controller #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       addr,
  input  logic             wr_en,
  input  logic [31:0]      wdata,
  input  logic             rd_en,
  output logic [31:0]      rdata,
  input  logic [WIDTH-1:0] pins_in,
  output logic [WIDTH-1:0] pins_out,
  output logic [WIDTH-1:0] pins_oe,
  output logic             irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] A_DATA_IN    = 3'd0;
  localparam logic [2:0] A_DATA_OUT   = 3'd1;
  localparam logic [2:0] A_DIR        = 3'd2;
  localparam logic [2:0] A_IRQ_EN     = 3'd3;
  localparam logic [2:0] A_EDGE_SEL   = 3'd4;
  localparam logic [2:0] A_IRQ_STATUS = 3'd5;

  logic [WIDTH-1:0] sync1_r, sync2_r, deb_r, deb_prev_r;
  logic [CW-1:0]    cnt_r [WIDTH];
  logic [WIDTH-1:0] data_out_r, dir_r, irq_en_r, edge_sel_r, status_r;
  logic [31:0]      rdata_r;

  logic [2:0]       sel_s;
  logic [WIDTH-1:0] wdata_s, rise_s, fall_s, event_s, w1c_s;
  logic [31:0]      rd_mux_s;
  logic             unused_s;

  assign sel_s    = addr[4:2];
  assign wdata_s  = wdata[WIDTH-1:0];
  assign unused_s = ^{addr[1:0], wdata};

  assign pins_out = data_out_r;
  assign pins_oe  = dir_r;
  assign irq      = |(status_r & irq_en_r);
  assign rdata    = rdata_r;

  // Edge detection on debounced inputs and write-1-to-clear mask
  always_comb begin
    rise_s  = deb_r & ~deb_prev_r;
    fall_s  = ~deb_r & deb_prev_r;
    event_s = (edge_sel_r & fall_s) | (~edge_sel_r & rise_s);
    if (wr_en && (sel_s == A_IRQ_STATUS)) begin
      w1c_s = wdata_s;
    end else begin
      w1c_s = '0;
    end
  end

  // Read multiplexer; unused upper bits and unmapped offsets return zero
  always_comb begin
    rd_mux_s = 32'd0;
    case (sel_s)
      A_DATA_IN:    rd_mux_s[WIDTH-1:0] = deb_r;
      A_DATA_OUT:   rd_mux_s[WIDTH-1:0] = data_out_r;
      A_DIR:        rd_mux_s[WIDTH-1:0] = dir_r;
      A_IRQ_EN:     rd_mux_s[WIDTH-1:0] = irq_en_r;
      A_EDGE_SEL:   rd_mux_s[WIDTH-1:0] = edge_sel_r;
      A_IRQ_STATUS: rd_mux_s[WIDTH-1:0] = status_r;
      default:      rd_mux_s = 32'd0;
    endcase
  end

  // Synchroniser and per-pin debounce counters
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r    <= '0;
      sync2_r    <= '0;
      deb_r      <= '0;
      deb_prev_r <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      sync1_r    <= pins_in;
      sync2_r    <= sync1_r;
      deb_prev_r <= deb_r;
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2_r[i] == deb_r[i]) begin
          cnt_r[i] <= '0;
        end else if (cnt_r[i] == CNT_LAST) begin
          deb_r[i] <= sync2_r[i];
          cnt_r[i] <= '0;
        end else begin
          cnt_r[i] <= cnt_r[i] + CW'(1);
        end
      end
    end
  end

  // Control registers; an event on the same edge as its W1C keeps the bit set
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_r <= '0;
      dir_r      <= '0;
      irq_en_r   <= '0;
      edge_sel_r <= '0;
      status_r   <= '0;
    end else begin
      if (wr_en) begin
        case (sel_s)
          A_DATA_OUT: data_out_r <= wdata_s;
          A_DIR:      dir_r      <= wdata_s;
          A_IRQ_EN:   irq_en_r   <= wdata_s;
          A_EDGE_SEL: edge_sel_r <= wdata_s;
          default:    ;
        endcase
      end
      status_r <= (status_r & ~w1c_s) | event_s;
    end
  end

  // Registered read data, sampled from pre-write register values
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_r <= 32'd0;
    end else if (rd_en) begin
      rdata_r <= rd_mux_s;
    end
  end

endmodule

// File: tb/tb_gpio_controller.sv
// Directed bench for gpio_controller: a register-access vector table followed
// by hand-written debounce, interrupt and reset sequences.
module tb_gpio_controller;

  logic        clk;
  logic        reset;
  logic [4:0]  addr;
  logic        wr_en;
  logic [31:0] wdata;
  logic        rd_en;
  logic [31:0] rdata;
  logic [7:0]  pins_in;
  logic [7:0]  pins_out;
  logic [7:0]  pins_oe;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;

  gpio_controller #(.WIDTH(8), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wr_en(wr_en), .wdata(wdata),
    .rd_en(rd_en), .rdata(rdata), .pins_in(pins_in), .pins_out(pins_out),
    .pins_oe(pins_oe), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [7:0]  exp_out;
    logic [7:0]  exp_oe;
  } vec_t;

  vec_t vecs [19];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wr_reg(input logic [4:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd_reg(input logic [4:0] a);
    addr  = a;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 5'h08, 32'h0000_00FF, 32'h0000_0000, 8'h00, 8'hFF};
    vecs[1]  = '{1'b1, 1'b0, 5'h04, 32'h0000_00A5, 32'h0000_0000, 8'hA5, 8'hFF};
    vecs[2]  = '{1'b0, 1'b1, 5'h04, 32'h0000_0000, 32'h0000_00A5, 8'hA5, 8'hFF};
    vecs[3]  = '{1'b1, 1'b1, 5'h04, 32'h0001_FF5A, 32'h0000_00A5, 8'h5A, 8'hFF};
    vecs[4]  = '{1'b0, 1'b1, 5'h04, 32'h0000_0000, 32'h0000_005A, 8'h5A, 8'hFF};
    vecs[5]  = '{1'b0, 1'b1, 5'h08, 32'h0000_0000, 32'h0000_00FF, 8'h5A, 8'hFF};
    vecs[6]  = '{1'b1, 1'b0, 5'h18, 32'hFFFF_FFFF, 32'h0000_00FF, 8'h5A, 8'hFF};
    vecs[7]  = '{1'b0, 1'b1, 5'h18, 32'h0000_0000, 32'h0000_0000, 8'h5A, 8'hFF};
    vecs[8]  = '{1'b0, 1'b1, 5'h08, 32'h0000_0000, 32'h0000_00FF, 8'h5A, 8'hFF};
    vecs[9]  = '{1'b1, 1'b1, 5'h1C, 32'hFFFF_FFFF, 32'h0000_0000, 8'h5A, 8'hFF};
    vecs[10] = '{1'b0, 1'b1, 5'h04, 32'h0000_0000, 32'h0000_005A, 8'h5A, 8'hFF};
    vecs[11] = '{1'b1, 1'b1, 5'h00, 32'h0000_00FF, 32'h0000_0000, 8'h5A, 8'hFF};
    vecs[12] = '{1'b1, 1'b0, 5'h0C, 32'h0000_000F, 32'h0000_0000, 8'h5A, 8'hFF};
    vecs[13] = '{1'b0, 1'b1, 5'h0D, 32'h0000_0000, 32'h0000_000F, 8'h5A, 8'hFF};
    vecs[14] = '{1'b1, 1'b1, 5'h10, 32'h0000_0004, 32'h0000_0000, 8'h5A, 8'hFF};
    vecs[15] = '{1'b0, 1'b1, 5'h10, 32'h0000_0000, 32'h0000_0004, 8'h5A, 8'hFF};
    vecs[16] = '{1'b0, 1'b1, 5'h14, 32'h0000_0000, 32'h0000_0000, 8'h5A, 8'hFF};
    vecs[17] = '{1'b0, 1'b1, 5'h08, 32'h0000_0000, 32'h0000_00FF, 8'h5A, 8'hFF};
    vecs[18] = '{1'b0, 1'b0, 5'h00, 32'h0000_0000, 32'h0000_00FF, 8'h5A, 8'hFF};

    reset   = 1'b1;
    addr    = 5'd0;
    wr_en   = 1'b0;
    wdata   = 32'd0;
    rd_en   = 1'b0;
    pins_in = 8'h00;
    repeat (3) tick();
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_pins_out", 32'(pins_out), 32'd0);
    chk("reset_pins_oe", 32'(pins_oe), 32'd0);
    chk("reset_irq", 32'(irq), 32'd0);
    reset = 1'b0;
    tick();

    // Register access table
    for (int v = 0; v < 19; v++) begin
      addr  = vecs[v].addr;
      wdata = vecs[v].wdata;
      wr_en = vecs[v].wr;
      rd_en = vecs[v].rd;
      tick();
      wr_en = 1'b0;
      rd_en = 1'b0;
      chk($sformatf("vec%0d_rdata", v), rdata, vecs[v].exp_rdata);
      chk($sformatf("vec%0d_pins_out", v), 32'(pins_out), 32'(vecs[v].exp_out));
      chk($sformatf("vec%0d_pins_oe", v), 32'(pins_oe), 32'(vecs[v].exp_oe));
    end

    // Rising debounce on bit 0 with IRQ_EN cleared; status polled continuously
    wr_reg(5'h0C, 32'h0);
    pins_in = 8'h01;
    addr    = 5'h14;
    rd_en   = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("rise_deb_e%0d", k), 32'(dut.deb_r[0]), (k >= 5) ? 32'd1 : 32'd0);
      chk($sformatf("rise_stat_e%0d", k), 32'(rdata[0]), (k >= 7) ? 32'd1 : 32'd0);
      chk($sformatf("rise_irq_e%0d", k), 32'(irq), 32'd0);
    end
    rd_en = 1'b0;
    wr_reg(5'h0C, 32'h1);
    chk("irq_enabled", 32'(irq), 32'd1);
    rd_reg(5'h00);
    chk("data_in_bit0", rdata, 32'h01);

    // Three-cycle glitch on bit 1 is rejected
    pins_in = 8'h03;
    repeat (3) tick();
    pins_in = 8'h01;
    repeat (10) tick();
    chk("glitch_cnt", 32'(dut.cnt_r[1]), 32'd0);
    rd_reg(5'h00);
    chk("glitch_data_in", rdata, 32'h01);
    rd_reg(5'h14);
    chk("glitch_status", rdata, 32'h01);

    // Falling-edge select on bit 2
    pins_in = 8'h05;
    repeat (8) tick();
    rd_reg(5'h00);
    chk("fall_data_in_hi", rdata, 32'h05);
    rd_reg(5'h14);
    chk("fall_no_rise_evt", rdata, 32'h01);
    pins_in = 8'h01;
    repeat (8) tick();
    rd_reg(5'h14);
    chk("fall_evt", rdata, 32'h05);

    // W1C colliding with a new event on bit 0
    wr_reg(5'h14, 32'h01);
    rd_reg(5'h14);
    chk("w1c_clear", rdata, 32'h04);
    pins_in = 8'h00;
    repeat (8) tick();
    rd_reg(5'h14);
    chk("no_evt_on_fall", rdata, 32'h04);
    pins_in = 8'h01;
    repeat (6) tick();
    wr_reg(5'h14, 32'h01);
    rd_reg(5'h14);
    chk("set_beats_w1c", rdata, 32'h05);
    chk("irq_after_collide", 32'(irq), 32'd1);
    wr_reg(5'h14, 32'h01);
    rd_reg(5'h14);
    chk("w1c_later", rdata, 32'h04);
    chk("irq_cleared", 32'(irq), 32'd0);
    wr_reg(5'h14, 32'h00);
    rd_reg(5'h14);
    chk("w0_no_effect", rdata, 32'h04);

    // Reset mid-debounce with loaded registers and concurrent strobes
    wr_reg(5'h0C, 32'h05);
    chk("irq_pre_reset", 32'(irq), 32'd1);
    pins_in = 8'h03;
    repeat (3) tick();
    reset = 1'b1;
    wr_en = 1'b1;
    addr  = 5'h04;
    wdata = 32'hFF;
    rd_en = 1'b1;
    tick();
    reset = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("rst_pins_out", 32'(pins_out), 32'd0);
    chk("rst_pins_oe", 32'(pins_oe), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_deb", 32'(dut.deb_r), 32'd0);
    chk("rst_cnt", 32'(dut.cnt_r[1]), 32'd0);
    rd_reg(5'h1C);
    chk("rd_offset7", rdata, 32'd0);
    repeat (4) tick();
    chk("post_rst_deb_e4", 32'(dut.deb_r), 32'd0);
    tick();
    chk("post_rst_deb_e5", 32'(dut.deb_r), 32'h03);
    tick();
    rd_reg(5'h14);
    chk("post_rst_status", rdata, 32'h03);
    chk("post_rst_irq", 32'(irq), 32'd0);
    rd_reg(5'h00);
    chk("post_rst_data_in", rdata, 32'h03);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gpio_controller.md
GPIO_CONTROLLER -- requirements
Module: gpio_controller

Interface
REQ-001 Parameter WIDTH, default 8: number of GPIO pins, 1..32.
REQ-002 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles needed to accept an input change, 1..65535.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 addr  input  5  byte address; only addr[4:2] is decoded.
REQ-006 wr_en  input  1  register write strobe, one cycle per write.
REQ-007 wdata  input  32  write data.
REQ-008 rd_en  input  1  register read strobe.
REQ-009 rdata  output  32  read data, registered.
REQ-010 pins_in  input  WIDTH  asynchronous external inputs.
REQ-011 pins_out  output  WIDTH  output values, equal to the DATA_OUT register.
REQ-012 pins_oe  output  WIDTH  per-pin output enable, equal to the DIR register; 1 = drive.
REQ-013 irq  output  1  level interrupt, equal to |(IRQ_STATUS & IRQ_EN).

Function
REQ-014 Register map (addr[4:2]):
- 0: DATA_IN, read-only, debounced inputs.
- 1: DATA_OUT, read/write.
- 2: DIR, read/write.
- 3: IRQ_EN, read/write.
- 4: EDGE_SEL, read/write; 0 = rising, 1 = falling.
- 5: IRQ_STATUS, read, write-1-to-clear.
REQ-015 Offsets 6..7 shall read 0; writes to them and to DATA_IN shall be ignored.
REQ-016 Register bits above WIDTH shall read 0; wdata bits above WIDTH shall be ignored.
REQ-017 rdata shall update on the edge where rd_en=1 and hold its value otherwise.
REQ-018 When rd_en and wr_en address the same register in one cycle, rdata shall return the pre-write value.
REQ-019 pins_in shall pass through a two-flop synchroniser per bit, giving sync.
REQ-020 Each bit shall have a debounced value deb and a counter cnt, width clog2(DEBOUNCE_CYCLES+1).
- On edges where sync==deb: cnt<=0.
- Where sync!=deb and cnt<DEBOUNCE_CYCLES-1: cnt increments.
- Where sync!=deb and cnt==DEBOUNCE_CYCLES-1: deb<=sync and cnt<=0.
REQ-021 A pins_in change stable before edge 0 and held shall update deb at edge 1+DEBOUNCE_CYCLES.
REQ-022 A glitch shorter than DEBOUNCE_CYCLES synchronised cycles shall not change deb; cnt shall return to 0.
REQ-023 deb_prev shall register deb every cycle.
- Rising event: deb & ~deb_prev.
- Falling event: ~deb & deb_prev.
REQ-024 IRQ_STATUS[i] shall set on the cycle after deb[i] changes in the direction selected by EDGE_SEL[i], regardless of IRQ_EN.
REQ-025 IRQ_STATUS bits shall be sticky until cleared by a write of 1.
REQ-026 If an event and a W1C of the same bit occur on the same edge, the set shall win and the bit shall read 1.
REQ-027 A write of 0 to an IRQ_STATUS bit shall leave it unchanged.
REQ-028 A change to EDGE_SEL shall not itself create an event; only deb transitions do.
REQ-029 irq shall be combinational from registered state, with no additional latency.
REQ-030 Writes shall take effect on the edge where wr_en=1; pins_out and pins_oe shall reflect them from that edge.

Reset
REQ-031 With reset=1 at an edge, all of the following shall clear to 0, overriding any concurrent wr_en or rd_en: synchroniser flops, deb, deb_prev, cnt, DATA_OUT, DIR, IRQ_EN, EDGE_SEL, IRQ_STATUS and rdata.
REQ-032 pins_out, pins_oe and irq shall be 0 while reset is held.
REQ-033 Deasserting reset with pins_in=1 shall follow the normal debounce path of REQ-020/REQ-021 and shall raise a rising event.
REQ-034 Reset asserted mid-debounce shall discard the partial count.

Verification
REQ-035 Write DIR=0xFF then DATA_OUT=0xA5 -> pins_oe=0xFF, pins_out=0xA5; read offset 1 -> rdata=0x000000A5 one edge after rd_en.
REQ-036 DEBOUNCE_CYCLES=4: set pins_in[0] 0->1 and hold -> deb[0] rises at edge 5, IRQ_STATUS[0]=1 at edge 6, irq=1 only with IRQ_EN[0]=1.
REQ-037 A 3-cycle pulse on pins_in[1] with DEBOUNCE_CYCLES=4 -> DATA_IN and IRQ_STATUS stay 0.
REQ-038 EDGE_SEL[2]=1, hold pins_in[2]=1, then drive it to 0 -> IRQ_STATUS[2] sets only on the falling transition.
REQ-039 W1C of IRQ_STATUS bit 0 on the same edge as a new event on bit 0 -> bit reads 1; W1C 0x01 later -> bit reads 0 and irq=0.
REQ-040 Assert reset mid-debounce with registers loaded -> all outputs and registers are 0 at the next edge; read offset 7 -> rdata=0.
